// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply engine and its operand store.
// Holds the FSM encoding, default bus widths, memory depths and the run-size helper.
package mm_pkg;

   localparam int MM_DW        = 32;
   localparam int MM_AW        = 16;
   localparam int MM_DEPTH_IN  = 1024;
   localparam int MM_DEPTH_W   = 1024;
   localparam int MM_DEPTH_OUT = 1024;
   localparam int MM_DIM_W     = 10;
   localparam int MM_CNT_W     = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mm_state_e;

   typedef struct packed {
      logic [MM_DIM_W-1:0] m;
      logic [MM_DIM_W-1:0] n;
   } mm_dims_t;

   // Number of result elements a run must produce, clipped to the result memory size.
   function automatic logic [MM_CNT_W-1:0] run_elems(input mm_dims_t dims, input int unsigned limit);
      logic [2*MM_DIM_W-1:0] prod;
      prod = dims.m * dims.n;
      if (32'(prod) > limit)
         return MM_CNT_W'(limit);
      return MM_CNT_W'(prod);
   endfunction

endpackage

// File: rtl/mm_result_tracker.sv
// Records which result addresses have been written this run and flags completion.
// Completion is combinational on the count after the current write; no backpressure.
module mm_result_tracker
   import mm_pkg::*;
#(
   parameter int DEPTH = MM_DEPTH_OUT,
   parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic [MM_CNT_W-1:0] target,
   input  logic                run,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_idx,
   output logic [MM_CNT_W-1:0] written_count,
   output logic                dup_err,
   output logic                complete
);

   logic [DEPTH-1:0]    written_q;
   logic [MM_CNT_W-1:0] count_q;
   logic [MM_CNT_W-1:0] target_q;
   logic [MM_CNT_W-1:0] count_nxt;
   logic                fresh;
   logic                dup;

   always_comb begin
      fresh     = wr_en && !written_q[wr_idx];
      dup       = wr_en && written_q[wr_idx];
      count_nxt = count_q + MM_CNT_W'(fresh);
      complete  = run && (count_nxt >= target_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         written_q <= '0;
         count_q   <= '0;
         target_q  <= '0;
         dup_err   <= 1'b0;
      end else if (clear) begin
         written_q <= '0;
         count_q   <= '0;
         target_q  <= target;
         dup_err   <= 1'b0;
      end else begin
         if (fresh)
            written_q[wr_idx] <= 1'b1;
         count_q <= count_nxt;
         if (dup)
            dup_err <= 1'b1;
      end
   end

   assign written_count = count_q;

endmodule

// File: rtl/matmul_operand_store.sv
// Operand/result memory for the matmul engine: zero-latency engine reads, 1-cycle readback.
// Host load and readback ports are ready only outside RUN; engine ports are never stalled.
module matmul_operand_store
   import mm_pkg::*;
#(
   parameter int DW        = MM_DW,
   parameter int AW        = MM_AW,
   parameter int DEPTH_IN  = MM_DEPTH_IN,
   parameter int DEPTH_W   = MM_DEPTH_W,
   parameter int DEPTH_OUT = MM_DEPTH_OUT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arm,
   input  logic [MM_DIM_W-1:0] m,
   input  logic [MM_DIM_W-1:0] n,
   // 'release' is a reserved word in SystemVerilog, hence the longer name.
   input  logic                run_release,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic                load_sel,
   input  logic [AW-1:0]       load_addr,
   input  logic [DW-1:0]       load_data,
   input  logic [AW-1:0]       input_addr,
   output logic [DW-1:0]       input_data,
   input  logic [AW-1:0]       weight_addr,
   output logic [DW-1:0]       weight_data,
   input  logic [AW-1:0]       output_addr,
   input  logic [DW-1:0]       output_data,
   input  logic                write_enable,
   input  logic                rd_req,
   output logic                rd_ready,
   input  logic [AW-1:0]       rd_addr,
   output logic                rd_valid,
   output logic [DW-1:0]       rd_data,
   output logic [1:0]          state,
   output logic [MM_CNT_W-1:0] written_count,
   output logic                result_ready,
   output logic                dup_err,
   output logic                oob_err
);

   localparam int IIW = (DEPTH_IN > 1) ? $clog2(DEPTH_IN) : 1;
   localparam int WIW = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
   localparam int OIW = (DEPTH_OUT > 1) ? $clog2(DEPTH_OUT) : 1;

   logic [DW-1:0] mem_in  [DEPTH_IN];
   logic [DW-1:0] mem_w   [DEPTH_W];
   logic [DW-1:0] mem_out [DEPTH_OUT];

   mm_state_e state_q;

   logic     running;
   logic     arm_acc;
   logic     load_fire;
   logic     ld_ok;
   logic     in_ok;
   logic     w_ok;
   logic     out_ok;
   logic     rdb_ok;
   logic     wr_acc;
   logic     rd_fire;
   logic     oob_set;
   logic     complete;
   mm_dims_t dims;

   always_comb begin
      running    = (state_q == ST_RUN);
      load_ready = !running;
      rd_ready   = !running;
      arm_acc    = arm && !running;
      load_fire  = load_valid && load_ready;
      rd_fire    = rd_req && rd_ready;
      ld_ok      = load_sel ? (32'(load_addr) < DEPTH_W) : (32'(load_addr) < DEPTH_IN);
      in_ok      = 32'(input_addr) < DEPTH_IN;
      w_ok       = 32'(weight_addr) < DEPTH_W;
      out_ok     = 32'(output_addr) < DEPTH_OUT;
      rdb_ok     = 32'(rd_addr) < DEPTH_OUT;
      wr_acc     = running && write_enable && out_ok;
      dims       = '{m: m, n: n};
      // Out-of-range engine traffic only counts as an error while a run is live.
      oob_set    = (load_fire && !ld_ok) ||
                   (running && (!in_ok || !w_ok || (write_enable && !out_ok)));
   end

   always_comb begin
      input_data  = '0;
      weight_data = '0;
      if (in_ok)
         input_data = mem_in[input_addr[IIW-1:0]];
      if (w_ok)
         weight_data = mem_w[weight_addr[WIW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (load_fire && ld_ok && !load_sel)
         mem_in[load_addr[IIW-1:0]] <= load_data;
      if (load_fire && ld_ok && load_sel)
         mem_w[load_addr[WIW-1:0]] <= load_data;
      if (wr_acc)
         mem_out[output_addr[OIW-1:0]] <= output_data;
   end

   mm_result_tracker #(
      .DEPTH (DEPTH_OUT),
      .IW    (OIW)
   ) u_tracker (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (arm_acc),
      .target        (run_elems(dims, DEPTH_OUT)),
      .run           (running),
      .wr_en         (wr_acc),
      .wr_idx        (output_addr[OIW-1:0]),
      .written_count (written_count),
      .dup_err       (dup_err),
      .complete      (complete)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         result_ready <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (complete) begin
                  state_q      <= ST_DONE;
                  result_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               // A fresh arm takes precedence over release so back-to-back runs never pass through IDLE.
               if (arm) begin
                  state_q      <= ST_RUN;
                  result_ready <= 1'b0;
               end else if (run_release) begin
                  state_q      <= ST_IDLE;
                  result_ready <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               result_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oob_err  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         oob_err  <= (oob_err && !arm_acc) || oob_set;
         rd_valid <= rd_fire;
         if (rd_fire)
            rd_data <= rdb_ok ? mem_out[rd_addr[OIW-1:0]] : '0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_matmul_operand_store.sv
// Self-checking bench for matmul_operand_store: emulates the engine through the read ports
// and compares against a reference matrix product and a set-based model of written addresses.
module tb_matmul_operand_store;

   localparam int DW        = 32;
   localparam int AW        = 16;
   localparam int DEPTH_IN  = 1024;
   localparam int DEPTH_W   = 1024;
   localparam int DEPTH_OUT = 1024;

   logic          clk;
   logic          rst_n;
   logic          arm;
   logic [9:0]    m;
   logic [9:0]    n;
   logic          run_release;
   logic          load_valid;
   logic          load_ready;
   logic          load_sel;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic [AW-1:0] input_addr;
   logic [DW-1:0] input_data;
   logic [AW-1:0] weight_addr;
   logic [DW-1:0] weight_data;
   logic [AW-1:0] output_addr;
   logic [DW-1:0] output_data;
   logic          write_enable;
   logic          rd_req;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [1:0]    state;
   logic [10:0]   written_count;
   logic          result_ready;
   logic          dup_err;
   logic          oob_err;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mdl_in  [DEPTH_IN];
   logic [DW-1:0] mdl_w   [DEPTH_W];
   logic [DW-1:0] mdl_out [DEPTH_OUT];
   bit            seen    [int];

   matmul_operand_store #(
      .DW(DW), .AW(AW), .DEPTH_IN(DEPTH_IN), .DEPTH_W(DEPTH_W), .DEPTH_OUT(DEPTH_OUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .m(m), .n(n), .run_release(run_release),
      .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data),
      .input_addr(input_addr), .input_data(input_data),
      .weight_addr(weight_addr), .weight_data(weight_data),
      .output_addr(output_addr), .output_data(output_data), .write_enable(write_enable),
      .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .state(state), .written_count(written_count), .result_ready(result_ready),
      .dup_err(dup_err), .oob_err(oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic sel, input int addr, input logic [DW-1:0] d);
      load_valid = 1'b1;
      load_sel   = sel;
      load_addr  = 16'(addr);
      load_data  = d;
      tick();
      load_valid = 1'b0;
      if (sel && addr < DEPTH_W) mdl_w[addr] = d;
      if (!sel && addr < DEPTH_IN) mdl_in[addr] = d;
   endtask

   task automatic arm_run(input int mm, input int nn);
      m   = 10'(mm);
      n   = 10'(nn);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      seen.delete();
   endtask

   task automatic release_run();
      run_release = 1'b1;
      tick();
      run_release = 1'b0;
   endtask

   task automatic eng_write(input int addr, input logic [DW-1:0] d, input bit accepted);
      write_enable = 1'b1;
      output_addr  = 16'(addr);
      output_data  = d;
      tick();
      write_enable = 1'b0;
      if (accepted) begin
         mdl_out[addr] = d;
         seen[addr]    = 1'b1;
      end
   endtask

   task automatic readback(input int addr, output logic v, output logic [DW-1:0] d);
      rd_req  = 1'b1;
      rd_addr = 16'(addr);
      tick();
      rd_req  = 1'b0;
      v       = rd_valid;
      d       = rd_data;
   endtask

   // Behaves like the engine: dot products taken through the combinational read ports.
   task automatic run_engine(input int mm, input int kk, input int nn);
      logic [DW-1:0] acc;
      for (int i = 0; i < mm; i++)
         for (int j = 0; j < nn; j++) begin
            acc = '0;
            for (int k = 0; k < kk; k++) begin
               input_addr  = 16'(i * kk + k);
               weight_addr = 16'(k * nn + j);
               #1;
               acc = acc + input_data * weight_data;
            end
            eng_write(i * nn + j, acc, 1'b1);
         end
      input_addr  = '0;
      weight_addr = '0;
   endtask

   function automatic logic [DW-1:0] ref_elem(input int i, input int j, input int kk, input int nn);
      logic [DW-1:0] s;
      s = '0;
      for (int k = 0; k < kk; k++) s = s + mdl_in[i * kk + k] * mdl_w[k * nn + j];
      return s;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++;
      if (load_ready !== 1'b1 || rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: load_ready=%b rd_ready=%b want 1/1", load_ready, rd_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (state !== 2'd0 || written_count !== 11'd0 || result_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_fsm: state=%0d count=%0d rr=%b want 0/0/0", state, written_count, result_ready);
      end
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== '0 || dup_err !== 1'b0 || oob_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: rd_valid=%b rd_data=%0h dup=%b oob=%b want all 0", rd_valid, rd_data, dup_err, oob_err);
      end
   endtask

   task automatic test_matmul_fixed();
      int            exp_fix [4] = '{58, 64, 139, 154};
      logic          v;
      logic [DW-1:0] d;
      for (int i = 0; i < 6; i++) load_word(1'b0, i, 32'(i + 1));
      for (int i = 0; i < 6; i++) load_word(1'b1, i, 32'(i + 7));
      arm_run(2, 2);
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL fixed_arm_state: state=%0d want 1", state);
      end
      run_engine(2, 3, 2);
      checks++;
      if (state !== 2'd2 || written_count !== 11'd4 || result_ready !== 1'b1) begin
         errors++;
         $display("FAIL fixed_done: state=%0d count=%0d rr=%b want 2/4/1", state, written_count, result_ready);
      end
      for (int a = 0; a < 4; a++) begin
         readback(a, v, d);
         checks++;
         if (v !== 1'b1 || d !== 32'(exp_fix[a])) begin
            errors++;
            $display("FAIL fixed_readback[%0d]: valid=%b data=%0d want 1/%0d", a, v, $signed(d), exp_fix[a]);
         end
      end
   endtask

   task automatic test_matmul_random();
      int            mm, kk, nn;
      logic          v;
      logic [DW-1:0] d;
      for (int it = 0; it < 3; it++) begin
         mm = $urandom_range(1, 4);
         kk = $urandom_range(1, 4);
         nn = $urandom_range(1, 4);
         for (int i = 0; i < mm * kk; i++) load_word(1'b0, i, 32'($urandom_range(0, 200)) - 32'd100);
         for (int i = 0; i < kk * nn; i++) load_word(1'b1, i, 32'($urandom_range(0, 200)) - 32'd100);
         arm_run(mm, nn);
         run_engine(mm, kk, nn);
         checks++;
         if (state !== 2'd2 || written_count !== 11'(seen.num()) || oob_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_done[%0d]: state=%0d count=%0d oob=%b want 2/%0d/0", it, state, written_count, oob_err, seen.num());
         end
         for (int i = 0; i < mm; i++)
            for (int j = 0; j < nn; j++) begin
               readback(i * nn + j, v, d);
               checks++;
               if (v !== 1'b1 || d !== ref_elem(i, j, kk, nn)) begin
                  errors++;
                  $display("FAIL rand_elem[%0d](%0d,%0d): valid=%b data=%0h want 1/%0h", it, i, j, v, d, ref_elem(i, j, kk, nn));
               end
            end
      end
   endtask

   task automatic test_dup();
      logic          v;
      logic [DW-1:0] d;
      arm_run(1, 2);
      eng_write(1, 32'd5, 1'b1);
      eng_write(1, 32'd9, 1'b1);
      checks++;
      if (dup_err !== 1'b1 || written_count !== 11'd1 || state !== 2'd1) begin
         errors++;
         $display("FAIL dup_mid: dup=%b count=%0d state=%0d want 1/1/1", dup_err, written_count, state);
      end
      eng_write(0, 32'd3, 1'b1);
      checks++;
      if (dup_err !== 1'b1 || written_count !== 11'd2 || state !== 2'd2) begin
         errors++;
         $display("FAIL dup_done: dup=%b count=%0d state=%0d want 1/2/2", dup_err, written_count, state);
      end
      readback(1, v, d);
      checks++;
      if (v !== 1'b1 || d !== mdl_out[1]) begin
         errors++;
         $display("FAIL dup_readback: valid=%b data=%0d want 1/%0d", v, d, mdl_out[1]);
      end
   endtask

   task automatic test_load_blocked();
      arm_run(1, 1);
      checks++;
      if (dup_err !== 1'b0) begin
         errors++;
         $display("FAIL arm_clears_dup: dup=%b want 0", dup_err);
      end
      load_valid = 1'b1;
      load_sel   = 1'b0;
      load_addr  = '0;
      load_data  = 32'hdead;
      #1;
      checks++;
      if (load_ready !== 1'b0 || rd_ready !== 1'b0) begin
         errors++;
         $display("FAIL run_ready: load_ready=%b rd_ready=%b want 0/0", load_ready, rd_ready);
      end
      tick();
      load_valid = 1'b0;
      eng_write(0, 32'd77, 1'b1);
      release_run();
      input_addr = '0;
      #1;
      checks++;
      if (state !== 2'd0 || input_data !== mdl_in[0]) begin
         errors++;
         $display("FAIL blocked_load: state=%0d input_data=%0h want 0/%0h", state, input_data, mdl_in[0]);
      end
      load_word(1'b0, 0, 32'h7);
      input_addr = '0;
      #1;
      checks++;
      if (input_data !== 32'h7) begin
         errors++;
         $display("FAIL load_commit: input_data=%0h want 7", input_data);
      end
   endtask

   task automatic test_oob();
      load_word(1'b0, DEPTH_IN, 32'h55);
      checks++;
      if (oob_err !== 1'b1) begin
         errors++;
         $display("FAIL oob_load: oob=%b want 1", oob_err);
      end
      arm_run(1, 1);
      checks++;
      if (oob_err !== 1'b0) begin
         errors++;
         $display("FAIL oob_arm_clear1: oob=%b want 0", oob_err);
      end
      input_addr = 16'(DEPTH_IN);
      #1;
      checks++;
      if (input_data !== '0) begin
         errors++;
         $display("FAIL oob_read_data: input_data=%0h want 0", input_data);
      end
      tick();
      input_addr = '0;
      checks++;
      if (oob_err !== 1'b1) begin
         errors++;
         $display("FAIL oob_read_flag: oob=%b want 1", oob_err);
      end
      eng_write(5, 32'd55, 1'b1);
      arm_run(1, 1);
      checks++;
      if (oob_err !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL oob_arm_clear2: oob=%b state=%0d want 0/1", oob_err, state);
      end
      eng_write(5, 32'd56, 1'b1);
   endtask

   task automatic test_reset_midrun();
      logic          v;
      logic [DW-1:0] d;
      arm_run(2, 2);
      for (int a = 10; a < 13; a++) eng_write(a, 32'($urandom), 1'b1);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++;
      if (state !== 2'd0 || written_count !== 11'd0 || result_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: state=%0d count=%0d rr=%b want 0/0/0", state, written_count, result_ready);
      end
      readback(11, v, d);
      checks++;
      if (v !== 1'b1 || d !== mdl_out[11]) begin
         errors++;
         $display("FAIL partial_kept: valid=%b data=%0h want 1/%0h", v, d, mdl_out[11]);
      end
      arm_run(1, 1);
      eng_write(13, 32'd99, 1'b1);
      checks++;
      if (state !== 2'd2 || written_count !== 11'd1) begin
         errors++;
         $display("FAIL rearm_done: state=%0d count=%0d want 2/1", state, written_count);
      end
   endtask

   task automatic test_zero_size();
      arm_run(0, 7);
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL zero_run: state=%0d want 1", state);
      end
      tick();
      checks++;
      if (state !== 2'd2 || written_count !== 11'd0 || result_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: state=%0d count=%0d rr=%b want 2/0/1", state, written_count, result_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] want;
      eng_write(0, 32'h1234, 1'b0);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_valid: rd_valid=%b want 0", rd_valid);
      end
      rd_req = 1'b1;
      for (int a = 0; a < 5; a++) begin
         rd_addr = (a == 4) ? 16'(DEPTH_OUT) : 16'(a);
         tick();
         want = (a == 4) ? '0 : mdl_out[a];
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== want) begin
            errors++;
            $display("FAIL b2b_resp[%0d]: valid=%b data=%0h want 1/%0h", a, rd_valid, rd_data, want);
         end
      end
      rd_req = 1'b0;
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end_valid: rd_valid=%b want 0", rd_valid);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      arm          = 1'b0;
      m            = '0;
      n            = '0;
      run_release  = 1'b0;
      load_valid   = 1'b0;
      load_sel     = 1'b0;
      load_addr    = '0;
      load_data    = '0;
      input_addr   = '0;
      weight_addr  = '0;
      output_addr  = '0;
      output_data  = '0;
      write_enable = 1'b0;
      rd_req       = 1'b0;
      rd_addr      = '0;
      for (int i = 0; i < DEPTH_OUT; i++) mdl_out[i] = '0;
      for (int i = 0; i < DEPTH_IN; i++) mdl_in[i] = '0;
      for (int i = 0; i < DEPTH_W; i++) mdl_w[i] = '0;
      test_reset();
      test_matmul_fixed();
      test_matmul_random();
      test_dup();
      test_load_blocked();
      test_oob();
      test_reset_midrun();
      test_zero_size();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
